lsu_axi_master: RTL and testbench
=================================

# lsu_axi_master

Parametrised load/store unit that turns one decoded memory request from the execute stage into a single AXI4-Lite read or write transaction, then returns the aligned, sign- or zero-extended result. It sits between the execute stage and the data-side AXI arbiter. Relative to the first-generation LSU it adds:
- configurable address and data width;
- byte-lane strobe generation for sub-word stores;
- a request/response handshake with back-pressure;
- explicit FSM sequencing of the read and write channels;
- bus-error reporting from RRESP/BRESP.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, bus data width; 32 or 64 only
- STRB_W, DATA_W/8, strobe width (derived; not overridden)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (dword legal only when DATA_W = 64)
- req_unsigned  in  1  zero-extend load result
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, LSB-aligned
- rsp_valid  out  1  response present; held until rsp_ready
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  extended load data; 0 for stores and on error
- rsp_err  out  1  bus error or misalign trap
- rsp_misalign  out  1  misalign trap flag
- AXI read channels: m_araddr out ADDR_W; m_arvalid out 1; m_arready in 1; m_rdata in DATA_W; m_rresp in 2; m_rvalid in 1; m_rready out 1
- AXI write channels: m_awaddr out ADDR_W; m_awvalid out 1; m_awready in 1; m_wdata out DATA_W; m_wstrb out STRB_W; m_wvalid out 1; m_wready in 1; m_bresp in 2; m_bvalid in 1; m_bready out 1

## Operation
- **States:** IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP.
- **Request capture:** req_ready = (state == IDLE). On acceptance, latch addr, size, unsigned and we; let off = addr[log2(STRB_W)-1:0].
  - Load → RD_ADDR.
  - Store → WR_REQ.
- **Store data path:** computed at acceptance and registered.
  - m_wdata = req_wdata << 8*off.
  - m_wstrb = ((1 << 2^size) - 1) << off, truncated to STRB_W.
- **RD_ADDR:** m_arvalid = 1. On m_arvalid && m_arready → RD_DATA.
- **RD_DATA:** m_rready = 1. On m_rvalid, register the result → RSP:
  - data = m_rdata >> 8*off;
  - extend from 8·2^size bits; sign-extend unless req_unsigned;
  - rsp_err = m_rresp[1];
  - rsp_rdata = 0 when rsp_err is set.
- **WR_REQ:**
  - m_awvalid and m_wvalid both assert on entry.
  - Each drops independently after its own handshake; done flags aw_done and w_done track this.
  - When both are done → WR_RESP. Same-cycle handshakes on AW and W are legal.
- **WR_RESP:** m_bready = 1. On m_bvalid → RSP; rsp_err = m_bresp[1].
- **RSP:** rsp_valid = 1. On rsp_ready → IDLE.
- **Single-outstanding rule:** no new request is accepted until the response has been consumed.
- **Address outputs:** m_araddr and m_awaddr carry the full latched byte address, unaligned bits included.
- **Bus protocol:** valid signals never drop before their handshake; address and data outputs stay stable while their valid is high.

## Timing
- **Reset (asynchronous, immediate):**
  - State → IDLE.
  - All valid/ready outputs = 0, except req_ready = 1.
  - rsp_rdata, rsp_err, rsp_misalign, m_wdata, m_wstrb, m_araddr, m_awaddr = 0.
  - Reset asserted mid-transaction abandons the transaction; there is no bus recovery.
- **Minimum load latency** (accept at cycle 0): m_arvalid at cycle 1; with m_arready at 1 and m_rvalid at 2, rsp_valid at cycle 3.
- **Minimum store latency:** AW/W valid at cycle 1; with both readies at 1 and m_bvalid at 2, rsp_valid at cycle 3.
- **Early response:** m_bvalid before both AW and W are done is ignored (m_bready = 0).
- **Back-pressure:** rsp_rdata and rsp_err are stable while rsp_valid && !rsp_ready.

## Configuration
- **LSU_MISALIGN_TRAP_EN defined:** a request with addr[size-1:0] != 0 goes IDLE → RSP with no bus activity. rsp_err = 1, rsp_misalign = 1, rsp_valid at cycle 1.
- **LSU_MISALIGN_TRAP_EN undefined:** misaligned requests are issued normally.
  - Strobe and data bits shifted past the bus word are dropped.
  - rsp_misalign is tied to 0.

## Structure
- **Package lsu_pkg:**
  - size encodings SZ_B, SZ_H, SZ_W, SZ_D;
  - state enum;
  - AXI response constants RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11.
- **Sub-module lsu_lane_align:** combinational helper for strobe generation, store shift, load shift and extension, instantiated once. Width and FSM logic stay in the top module.

## Test plan
- **lb, unsigned = 0:** addr 0x8000_0003, rdata 0x80FF_1234 (DATA_W = 32) → rsp_rdata 0xFFFF_FF80, rsp_err 0.
- **sh:** addr 0x8000_0002, wdata 0x0000_ABCD → m_wdata 0xABCD_0000, m_wstrb 4'b1100, m_awaddr 0x8000_0002.
- **Staggered store handshakes:** m_wready at cycle 1, m_awready at cycle 4, m_bvalid at cycle 2 and cycle 6 → m_bready first high at cycle 5; rsp_valid at cycle 7; awvalid held through cycle 4.
- **Load with m_rresp = 2'b11** → rsp_err 1, rsp_rdata 0. Then hold rsp_ready = 0 for 3 cycles → rsp_valid held and req_ready 0 throughout.
- **LSU_MISALIGN_TRAP_EN defined, lw at 0x8000_0001** → no m_arvalid; rsp_valid cycle 1 with rsp_err 1, rsp_misalign 1.
- **rst_n pulled low in RD_DATA** → m_rready, rsp_valid = 0 in the same cycle; req_ready = 1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and AXI response codes.
// Optional feature macro used by lsu_axi_master: LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StRdAddr,
        StRdData,
        StWrReq,
        StWrResp,
        StRsp
    } lsu_state_e;

    // Byte-enable pattern for an access of the given size, before lane shifting.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        logic [7:0] m;
        unique case (size)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0f;
            default: m = 8'hff;
        endcase
        return m;
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input logic [1:0] size);
        logic [2:0] m;
        unique case (size)
            SZ_B:    m = 3'b000;
            SZ_H:    m = 3'b001;
            SZ_W:    m = 3'b011;
            default: m = 3'b111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane helper: store shift and strobes, load shift and sign/zero extension.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned STRB_W = DATA_W / 8,
    parameter int unsigned OFF_W  = $clog2(STRB_W)
) (
    input  logic [OFF_W-1:0]  off_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [DATA_W-1:0] st_data_i,
    output logic [DATA_W-1:0] st_data_o,
    output logic [STRB_W-1:0] st_strb_o,
    input  logic [DATA_W-1:0] ld_data_i,
    output logic [DATA_W-1:0] ld_data_o
);

    logic [7:0]        strb_full;
    logic [DATA_W-1:0] ld_sh;
    logic              sign;
    logic              fill;
    int                nbits;

    always_comb begin
        // Lanes shifted past the bus word fall off the top.
        strb_full = size_mask(size_i) << off_i;
        st_strb_o = strb_full[STRB_W-1:0];
        st_data_o = st_data_i << {off_i, 3'b000};

        ld_sh = ld_data_i >> {off_i, 3'b000};
        nbits = 8 << size_i;
        unique case (size_i)
            SZ_B:    sign = ld_sh[7];
            SZ_H:    sign = ld_sh[15];
            SZ_W:    sign = ld_sh[31];
            default: sign = ld_sh[DATA_W-1];
        endcase
        fill = sign & ~unsigned_i;
        for (int i = 0; i < DATA_W; i++) begin
            ld_data_o[i] = (i < nbits) ? ld_sh[i] : fill;
        end
    end

endmodule

// File: rtl/lsu_axi_master.sv
// Single-outstanding load/store unit issuing one AXI4-Lite read or write per request.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_axi_master
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              rsp_misalign_o,
    output logic [ADDR_W-1:0] m_araddr_o,
    output logic              m_arvalid_o,
    input  logic              m_arready_i,
    input  logic [DATA_W-1:0] m_rdata_i,
    input  logic [1:0]        m_rresp_i,
    input  logic              m_rvalid_i,
    output logic              m_rready_o,
    output logic [ADDR_W-1:0] m_awaddr_o,
    output logic              m_awvalid_o,
    input  logic              m_awready_i,
    output logic [DATA_W-1:0] m_wdata_o,
    output logic [STRB_W-1:0] m_wstrb_o,
    output logic              m_wvalid_o,
    input  logic              m_wready_i,
    input  logic [1:0]        m_bresp_i,
    input  logic              m_bvalid_i,
    output logic              m_bready_o
);

    localparam int unsigned OFF_W = $clog2(STRB_W);

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [OFF_W-1:0]  off_sel;
    logic [1:0]        size_sel;
    logic [DATA_W-1:0] st_data;
    logic [STRB_W-1:0] st_strb;
    logic [DATA_W-1:0] ld_data;
    logic              unused_resp_lsb;

    // Only the error bit of RRESP/BRESP matters; EXOKAY is treated as OKAY.
    assign unused_resp_lsb = m_rresp_i[0] ^ m_bresp_i[0];

    // Store alignment uses the live request; load alignment uses the latched one.
    assign off_sel  = (state_q == StIdle) ? req_addr_i[OFF_W-1:0] : addr_q[OFF_W-1:0];
    assign size_sel = (state_q == StIdle) ? req_size_i : size_q;

    lsu_lane_align #(
        .DATA_W (DATA_W),
        .STRB_W (STRB_W),
        .OFF_W  (OFF_W)
    ) u_lane_align (
        .off_i      (off_sel),
        .size_i     (size_sel),
        .unsigned_i (uns_q),
        .st_data_i  (req_wdata_i),
        .st_data_o  (st_data),
        .st_strb_o  (st_strb),
        .ld_data_i  (m_rdata_i),
        .ld_data_o  (ld_data)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
    logic req_misalign;
    assign req_misalign   = |(req_addr_i[2:0] & align_mask(req_size_i));
    assign rsp_misalign_o = misalign_q;
`else
    assign rsp_misalign_o = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        uns_d     = uns_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        m_arvalid_o = 1'b0;
        m_rready_o  = 1'b0;
        m_awvalid_o = 1'b0;
        m_wvalid_o  = 1'b0;
        m_bready_o  = 1'b0;

        unique case (state_q)
            StIdle: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    addr_d    = req_addr_i;
                    size_d    = req_size_i;
                    uns_d     = req_unsigned_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    rdata_d   = '0;
                    err_d     = 1'b0;
                    if (req_we_i) begin
                        wdata_d = st_data;
                        wstrb_d = st_strb;
                        state_d = StWrReq;
                    end else begin
                        state_d = StRdAddr;
                    end
`ifdef LSU_MISALIGN_TRAP_EN
                    misalign_d = 1'b0;
                    if (req_misalign) begin
                        err_d      = 1'b1;
                        misalign_d = 1'b1;
                        state_d    = StRsp;
                    end
`endif
                end
            end
            StRdAddr: begin
                m_arvalid_o = 1'b1;
                if (m_arready_i) state_d = StRdData;
            end
            StRdData: begin
                m_rready_o = 1'b1;
                if (m_rvalid_i) begin
                    err_d   = m_rresp_i[1];
                    rdata_d = m_rresp_i[1] ? '0 : ld_data;
                    state_d = StRsp;
                end
            end
            StWrReq: begin
                m_awvalid_o = ~aw_done_q;
                m_wvalid_o  = ~w_done_q;
                aw_done_d   = aw_done_q | m_awready_i;
                w_done_d    = w_done_q | m_wready_i;
                if (aw_done_d && w_done_d) state_d = StWrResp;
            end
            StWrResp: begin
                m_bready_o = 1'b1;
                if (m_bvalid_i) begin
                    err_d   = m_bresp_i[1];
                    state_d = StRsp;
                end
            end
            StRsp: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            size_q    <= SZ_B;
            uns_q     <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_q <= 1'b0;
        else        misalign_q <= misalign_d;
    end
`endif

    assign m_araddr_o  = addr_q;
    assign m_awaddr_o  = addr_q;
    assign m_wdata_o   = wdata_q;
    assign m_wstrb_o   = wstrb_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Randomized bench for lsu_axi_master against a byte-level reference model (DATA_W = 32).
module tb_lsu_axi_master;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_misalign;
    logic [31:0] rsp_rdata;
    logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [1:0]  m_rresp, m_bresp;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [3:0]  m_wstrb;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lsu_axi_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_we_i       (req_we),
        .req_size_i     (req_size),
        .req_unsigned_i (req_unsigned),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_rdata_o    (rsp_rdata),
        .rsp_err_o      (rsp_err),
        .rsp_misalign_o (rsp_misalign),
        .m_araddr_o     (m_araddr),
        .m_arvalid_o    (m_arvalid),
        .m_arready_i    (m_arready),
        .m_rdata_i      (m_rdata),
        .m_rresp_i      (m_rresp),
        .m_rvalid_i     (m_rvalid),
        .m_rready_o     (m_rready),
        .m_awaddr_o     (m_awaddr),
        .m_awvalid_o    (m_awvalid),
        .m_awready_i    (m_awready),
        .m_wdata_o      (m_wdata),
        .m_wstrb_o      (m_wstrb),
        .m_wvalid_o     (m_wvalid),
        .m_wready_i     (m_wready),
        .m_bresp_i      (m_bresp),
        .m_bvalid_i     (m_bvalid),
        .m_bready_o     (m_bready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load result assembled byte by byte; bytes past the bus word read as zero.
    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size,
                                               input logic uns, input logic [31:0] rdata);
        logic [31:0] v;
        int off, nb;
        v   = '0;
        off = int'(addr[1:0]);
        nb  = 1 << size;
        for (int k = 0; k < nb; k++)
            if (off + k < 4) v[8*k +: 8] = rdata[8*(off+k) +: 8];
        if (!uns && nb < 4 && v[8*nb-1])
            for (int j = nb; j < 4; j++) v[8*j +: 8] = 8'hff;
        return v;
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [1:0] size,
                               input logic [31:0] wdata,
                               output logic [31:0] wd, output logic [3:0] strb);
        int off, nb;
        off  = int'(addr[1:0]);
        nb   = 1 << size;
        wd   = '0;
        strb = '0;
        for (int j = 0; j < 4; j++) begin
            if (j >= off) begin
                wd[8*j +: 8] = wdata[8*(j-off) +: 8];
                strb[j]      = (j - off) < nb;
            end
        end
    endtask

    task automatic clear_bus();
        m_arready = 0; m_rvalid = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;
        m_rdata = $urandom; m_rresp = 2'b00; m_bresp = 2'b00;
    endtask

    // One request with a responsive slave; d_* are ready/valid delays in cycles.
    task automatic xfer(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input logic [1:0] resp,
                        input int d_a, input int d_w, input int d_b, input int hold,
                        output int lat, output logic [31:0] got);
        logic [31:0] exp_rd, exp_wd;
        logic [3:0]  exp_strb;
        logic        exp_err, exp_mis;
        bit          a_hs, w_hs, a_new, w_new;
        int          n_a, n_w, n_b;
        exp_mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        exp_mis = (addr[1:0] & ((2'd1 << size) - 2'd1)) != 2'd0;
`endif
        exp_err = exp_mis ? 1'b1 : resp[1];
        exp_rd  = (we || exp_err) ? 32'h0 : model_load(addr, size, uns, rdata);
        model_store(addr, size, wdata, exp_wd, exp_strb);

        chk("req_ready_idle", req_ready, 1);
        req_valid = 1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        tick();
        req_valid = 0; req_we = $urandom; req_size = $urandom; req_unsigned = $urandom;
        req_addr = $urandom; req_wdata = $urandom;

        lat = -1; a_hs = 0; w_hs = 0; n_a = 0; n_w = 0; n_b = 0;
        for (int c = 1; c <= 100; c++) begin
            if (rsp_valid) begin
                lat = c;
                break;
            end
            clear_bus();
            if (!we) begin
                if (a_hs) begin
                    chk("arvalid_drop", m_arvalid, 0);
                    chk("rready", m_rready, 1);
                    m_rdata = rdata; m_rresp = resp; m_rvalid = n_b >= d_b; n_b++;
                end else begin
                    chk("arvalid", m_arvalid, 1);
                    chk("araddr", m_araddr, addr);
                    m_arready = n_a >= d_a; n_a++;
                    a_hs = m_arready;
                end
            end else begin
                if (a_hs && w_hs) begin
                    chk("bready", m_bready, 1);
                    m_bresp = resp; m_bvalid = n_b >= d_b; n_b++;
                end else begin
                    m_bvalid = 1'($urandom_range(0, 1)); m_bresp = 2'($urandom);
                    chk("bready_early", m_bready, 0);
                end
                a_new = a_hs; w_new = w_hs;
                if (!a_hs) begin
                    chk("awvalid", m_awvalid, 1);
                    chk("awaddr", m_awaddr, addr);
                    m_awready = n_a >= d_a; n_a++;
                    a_new = m_awready;
                end else begin
                    chk("awvalid_drop", m_awvalid, 0);
                end
                if (!w_hs) begin
                    chk("wvalid", m_wvalid, 1);
                    chk("wdata", m_wdata, exp_wd);
                    chk("wstrb", m_wstrb, exp_strb);
                    m_wready = n_w >= d_w; n_w++;
                    w_new = m_wready;
                end else begin
                    chk("wvalid_drop", m_wvalid, 0);
                end
                a_hs = a_new; w_hs = w_new;
            end
            tick();
        end
        clear_bus();
        chk("rsp_timeout", lat > 0, 1);
        if (exp_mis) chk("lat_trap", lat, 1);
        else if (d_a == 0 && d_b == 0 && (!we || d_w == 0)) chk("lat_min", lat, 3);
        got = rsp_rdata;
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_misalign", rsp_misalign, exp_mis);
        chk("req_ready_busy", req_ready, 0);
        chk("no_arvalid_rsp", m_arvalid, 0);
        rsp_ready = 0;
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("rsp_valid_hold", rsp_valid, 1);
            chk("rsp_rdata_hold", rsp_rdata, exp_rd);
            chk("rsp_err_hold", rsp_err, exp_err);
            chk("req_ready_hold", req_ready, 0);
        end
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        chk("rsp_consumed", rsp_valid, 0);
        chk("req_ready_back", req_ready, 1);
    endtask

    initial begin
        int          lat;
        logic [31:0] got;
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;

        rst_n = 0; req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
        req_addr = 0; req_wdata = 0; rsp_ready = 0;
        clear_bus();
        #12;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_arvalid", m_arvalid, 0);
        chk("rst_awvalid", {m_awvalid, m_wvalid, m_rready, m_bready}, 0);
        chk("rst_addr", {m_araddr, m_awaddr}, 0);
        chk("rst_wdata", {m_wdata, 28'h0, m_wstrb}, 0);
        chk("rst_rsp", {rsp_rdata, rsp_err, rsp_misalign}, 0);
        @(negedge clk);
        rst_n = 1;
        tick();

        // lb sign-extended from the top lane
        xfer(0, SZ_B, 0, 32'h8000_0003, 32'h0, 32'h80FF_1234, RESP_OKAY, 0, 0, 0, 0, lat, got);
        chk("lb_const", got, 32'hFFFF_FF80);
        // minimum-latency store
        xfer(1, SZ_W, 0, 32'h8000_0010, 32'h1234_5678, 32'h0, RESP_OKAY, 0, 0, 0, 0, lat, got);
        // load error with back-pressure
        xfer(0, SZ_W, 0, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, RESP_DECERR, 0, 0, 0, 3, lat, got);
        chk("err_rdata_const", got, 0);
        // store error
        xfer(1, SZ_B, 1, 32'h8000_0001, 32'h55, 32'h0, RESP_SLVERR, 1, 0, 2, 1, lat, got);
`ifdef LSU_MISALIGN_TRAP_EN
        xfer(0, SZ_W, 0, 32'h8000_0001, 32'h0, 32'h1111_2222, RESP_OKAY, 0, 0, 0, 0, lat, got);
        chk("trap_lat", lat, 1);
`endif

        // sh with staggered AW/W handshakes and an early BVALID
        req_valid = 1; req_we = 1; req_size = SZ_H; req_unsigned = 0;
        req_addr = 32'h8000_0002; req_wdata = 32'h0000_ABCD;
        tick();                                        // cycle 1
        req_valid = 0; req_addr = $urandom; req_wdata = $urandom;
        chk("stg_awvalid1", m_awvalid, 1);
        chk("stg_wvalid1", m_wvalid, 1);
        chk("sh_wdata", m_wdata, 32'hABCD_0000);
        chk("sh_wstrb", m_wstrb, 4'b1100);
        chk("sh_awaddr", m_awaddr, 32'h8000_0002);
        m_wready = 1;
        tick();                                        // cycle 2
        m_wready = 0; m_bvalid = 1; m_bresp = RESP_SLVERR;
        chk("stg_wvalid2", m_wvalid, 0);
        chk("stg_awvalid2", m_awvalid, 1);
        chk("stg_bready2", m_bready, 0);
        tick();                                        // cycle 3
        m_bvalid = 0;
        chk("stg_awvalid3", m_awvalid, 1);
        chk("stg_bready3", m_bready, 0);
        tick();                                        // cycle 4
        chk("stg_awvalid4", m_awvalid, 1);
        chk("stg_awaddr4", m_awaddr, 32'h8000_0002);
        m_awready = 1;
        tick();                                        // cycle 5
        m_awready = 0;
        chk("stg_awvalid5", m_awvalid, 0);
        chk("stg_bready5", m_bready, 1);
        tick();                                        // cycle 6
        chk("stg_rsp6", rsp_valid, 0);
        m_bvalid = 1; m_bresp = RESP_OKAY;
        tick();                                        // cycle 7
        m_bvalid = 0;
        chk("stg_rsp7", rsp_valid, 1);
        chk("stg_err", rsp_err, 0);
        chk("stg_rdata", rsp_rdata, 0);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        chk("stg_idle", req_ready, 1);

        // reset while waiting in the read-data phase
        req_valid = 1; req_we = 0; req_size = SZ_W; req_addr = 32'h8000_0040;
        tick();
        req_valid = 0;
        m_arready = 1;
        tick();
        m_arready = 0;
        chk("pre_rst_rready", m_rready, 1);
        #2 rst_n = 0;
        #1;
        chk("rst_mid_rready", m_rready, 0);
        chk("rst_mid_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        rst_n = 1;
        tick();
        chk("rst_mid_req_ready", req_ready, 1);

        for (int t = 0; t < 60; t++) begin
            we   = 1'($urandom);
            size = 2'($urandom_range(0, 2));
            addr = $urandom;
            if ($urandom_range(0, 1) == 0) addr = addr & ~((32'd1 << size) - 32'd1);
            if ($urandom_range(0, 3) == 0)
                xfer(we, size, 1'($urandom), addr, $urandom, $urandom, 2'($urandom),
                     0, 0, 0, 0, lat, got);
            else
                xfer(we, size, 1'($urandom), addr, $urandom, $urandom, 2'($urandom),
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 2), lat, got);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
